// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter with a one-entry holding register
module uart_tx #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       i_Clock,
    input  logic       i_Rst_L,
    input  logic       i_Tx_DV,
    input  logic [7:0] i_Tx_Byte,
    output logic       o_Tx_Ready,
    output logic       o_Tx_Active,
    output logic       o_Tx_Serial,
    output logic       o_Tx_Done
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic [7:0]       hold_byte;
    logic             hold_valid;
    logic             bit_last;
    logic             frame_end;
    logic             hold_load;

    assign bit_last   = (clk_cnt == LAST_CNT);
    assign frame_end  = (state == STOP) && bit_last;
    // At the final stop edge an empty holding register is bypassed: the byte goes straight to the shifter
    assign hold_load  = i_Tx_DV && !hold_valid && (state != IDLE) && !frame_end;
    assign o_Tx_Ready = !hold_valid;

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state       <= IDLE;
            clk_cnt     <= '0;
            bit_idx     <= '0;
            shift_reg   <= '0;
            hold_byte   <= '0;
            hold_valid  <= 1'b0;
            o_Tx_Serial <= 1'b1;
            o_Tx_Active <= 1'b0;
            o_Tx_Done   <= 1'b0;
        end else begin
            o_Tx_Done <= 1'b0;

            if (hold_load) begin
                hold_byte  <= i_Tx_Byte;
                hold_valid <= 1'b1;
            end

            if (state == IDLE || bit_last) begin
                clk_cnt <= '0;
            end else begin
                clk_cnt <= clk_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    bit_idx <= '0;
                    if (i_Tx_DV) begin
                        shift_reg   <= i_Tx_Byte;
                        state       <= START;
                        o_Tx_Serial <= 1'b0;
                        o_Tx_Active <= 1'b1;
                    end
                end
                START: begin
                    if (bit_last) begin
                        state       <= DATA;
                        bit_idx     <= '0;
                        o_Tx_Serial <= shift_reg[0];
                    end
                end
                DATA: begin
                    if (bit_last) begin
                        if (bit_idx == 3'd7) begin
                            state       <= STOP;
                            o_Tx_Serial <= 1'b1;
                        end else begin
                            bit_idx     <= bit_idx + 3'd1;
                            o_Tx_Serial <= shift_reg[bit_idx + 3'd1];
                        end
                    end
                end
                STOP: begin
                    if (bit_last) begin
                        o_Tx_Done <= 1'b1;
                        if (hold_valid) begin
                            shift_reg   <= hold_byte;
                            hold_valid  <= 1'b0;
                            state       <= START;
                            o_Tx_Serial <= 1'b0;
                        end else if (i_Tx_DV) begin
                            shift_reg   <= i_Tx_Byte;
                            state       <= START;
                            o_Tx_Serial <= 1'b0;
                        end else begin
                            state       <= IDLE;
                            o_Tx_Active <= 1'b0;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    hold_valid  <= 1'b0;
                    o_Tx_Serial <= 1'b1;
                    o_Tx_Active <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/uart_tx.md
# uart_tx

Transmits 8N1 UART frames: 1 start bit, 8 data bits LSB first, 1 stop bit, each exactly CLKS_PER_BIT clocks, with a one-entry holding register so frames can go out back-to-back with no idle gap. It sits between on-chip byte producers and the serial pin. It is the transmitting end of the UART link whose receiver samples with the same CLKS_PER_BIT.

## Interface
- CLKS_PER_BIT, 87, clocks per serial bit (integer ≥ 2); bit counter width is $clog2(CLKS_PER_BIT)
- i_Clock  input  1  system clock, all logic on rising edge
- i_Rst_L  input  1  asynchronous, active-low reset
- i_Tx_DV  input  1  byte-valid strobe, sampled each rising edge
- i_Tx_Byte  input  8  byte to send, captured when i_Tx_DV && o_Tx_Ready
- o_Tx_Ready  output  1  holding register empty; a strobe is accepted this cycle
- o_Tx_Active  output  1  high while a frame (start, data or stop bit) is on the line
- o_Tx_Serial  output  1  serial line, registered, idle high
- o_Tx_Done  output  1  one-cycle pulse after each stop bit completes

## Operation
- Reset values: o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Tx_Ready=1. State is IDLE. Bit counter, bit index and holding-valid flag are all 0.
- States: IDLE, START, DATA, STOP. No other states. Unreachable encodings return to IDLE.
- Acceptance: a strobe is accepted when i_Tx_DV=1 and o_Tx_Ready=1 at the edge. A strobe with o_Tx_Ready=0 is dropped silently and has no other effect.
- o_Tx_Ready = !hold_valid.
- IDLE:
  - An accepted byte loads the shift register directly, bypassing the holding register. Next state is START.
  - hold_valid is always 0 in IDLE.
- START, DATA, STOP: an accepted byte goes into the holding register and hold_valid is set.
- START: o_Tx_Serial=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
- DATA: o_Tx_Serial=shift[bit index] for CLKS_PER_BIT cycles per bit. After bit 7, go to STOP.
- STOP: o_Tx_Serial=1 for CLKS_PER_BIT cycles. At the last-cycle edge (counter == CLKS_PER_BIT-1):
  - If hold_valid: load the holding register into the shift register, clear hold_valid, go to START.
  - Else if i_Tx_DV: load i_Tx_Byte directly into the shift register, go to START.
  - Else: go to IDLE.
  - In all three cases o_Tx_Done is registered high for the following cycle only.
- Bit counter: 0..CLKS_PER_BIT-1. It clears on every bit boundary and never wraps past CLKS_PER_BIT-1.
- o_Tx_Active=1 exactly while the state is START, DATA or STOP.
- Reset asserted mid-frame: all outputs return to reset values immediately (asynchronous), the holding byte is discarded, and no o_Tx_Done is issued. The truncated frame on the line is accepted behaviour.

## Timing
- Latency from IDLE: strobe sampled at edge k → o_Tx_Serial=0 and o_Tx_Active=1 from edge k onward (registered, so visible after edge k).
- Frame length is exactly 10×CLKS_PER_BIT cycles, measured from start-bit fall to the end of the stop bit.
- Back-to-back: if the next byte is held or strobed at the final stop edge, the next start bit begins on that same edge. The frame period is exactly 10×CLKS_PER_BIT with zero idle cycles between frames.
- During a back-to-back transition o_Tx_Active stays 1 continuously, and o_Tx_Done pulses in the first cycle of the new start bit.
- o_Tx_Ready falls on the edge after acceptance into the holding register. It rises on the final stop edge that consumes the holding register.
- Throughput: at most one strobe is accepted per frame while busy. Producers must gate on o_Tx_Ready.

## Test plan
- Single byte, CLKS_PER_BIT=4: strobe 0xA5 from IDLE.
  - Line pattern (4 clocks each): 0,1,0,1,0,0,1,0,1,1.
  - o_Tx_Done pulses once, 40 cycles after the start fall. Then IDLE with o_Tx_Active=0.
- Back-to-back:
  - Strobe 0x3C, then strobe 0xC3 during the data bits of the first frame.
  - Required: o_Tx_Ready goes 0, no idle cycle between frames, 80 cycles total, two o_Tx_Done pulses 40 cycles apart.
- Overflow: with the holding register full, strobe 0x77.
  - Required: 0x77 is dropped; only the first two bytes are transmitted.
- Strobe at final stop cycle, holding register empty: strobe 0x81 exactly at that edge.
  - Required: 0x81's start bit begins immediately and o_Tx_Done pulses once.
- Reset mid-frame: assert i_Rst_L=0 during data bit 3 with a byte held.
  - Required: o_Tx_Serial=1 and o_Tx_Ready=1 immediately, no o_Tx_Done, and the held byte is never sent.
- Loopback into the team's receiver, CLKS_PER_BIT=87:
  - Send 0x00, 0xFF, 0x55, 0xAA back-to-back.
  - Required: the receiver outputs all four bytes in order, with one valid pulse each.
